term_loopback_cfg: RTL and testbench

Parametrised, configurable successor to the fixed north-terminating RAM_IO switch matrix. It sits in a fabric edge terminating tile and loops incoming N-direction wire bundles (N1END, N2MID, N2END, N4END) back onto the outgoing S-direction bundles (S1BEG, S2BEG, S2BEGb, S4BEG). Index order is reversed within each bundle. Each channel has a configurable mode: combinational, 1-stage registered, 2-stage registered, or forced 0. Modes are loaded through a double-buffered serial configuration chain.

---
 rtl/term_loopback_cfg_if.sv | 15 +
 rtl/term_loopback_cfg.sv | 57 +++++
 tb/tb_term_loopback_cfg.sv | 124 ++++++++++++
 3 files changed

// File: rtl/term_loopback_cfg_if.sv
// term_loopback_cfg_if: wire bundles and serial config chain of a loopback tile
interface term_loopback_cfg_if #(parameter int CH = 36);
  logic [CH-1:0] end_in;
  logic [CH-1:0] beg_out;
  logic          cfg_shift_en;
  logic          cfg_din;
  logic          cfg_dout;
  logic          cfg_commit;
  logic          cfg_full;
  logic          cfg_err;
  modport master (output end_in, cfg_shift_en, cfg_din, cfg_commit,
                  input  beg_out, cfg_dout, cfg_full, cfg_err);
  modport slave  (input  end_in, cfg_shift_en, cfg_din, cfg_commit,
                  output beg_out, cfg_dout, cfg_full, cfg_err);
endinterface

// File: rtl/term_loopback_cfg.sv
// term_loopback_cfg: N->S edge loopback with per-channel comb/1-reg/2-reg/zero modes
module term_loopback_cfg #(
  parameter int W1 = 4,
  parameter int W2 = 8,
  parameter int W4 = 16
) (
  input logic UserCLK,
  input logic resetn,
  term_loopback_cfg_if.slave bus
);
  localparam int CH = W1 + 2 * W2 + W4;
  localparam int CW = $clog2(2 * CH + 1);
  logic [CH-1:0]   rev, p1, p2, beg;
  logic [2*CH-1:0] shadow, active;
  logic [CW-1:0]   cnt;
  logic            err, full, legal;
  assign full  = cnt == CW'(2 * CH);
  assign legal = bus.cfg_commit & full & ~bus.cfg_shift_en;
  assign bus.cfg_full = full;
  assign bus.cfg_err  = err;
  assign bus.cfg_dout = shadow[2*CH-1];
  assign bus.beg_out  = beg;
  always_comb begin
    rev = '0;
    for (int k = 0; k < W1; k++) rev[k] = bus.end_in[W1-1-k];
    for (int k = 0; k < W2; k++) rev[W1+k] = bus.end_in[W1+W2-1-k];
    for (int k = 0; k < W2; k++) rev[W1+W2+k] = bus.end_in[W1+2*W2-1-k];
    for (int k = 0; k < W4; k++) rev[W1+2*W2+k] = bus.end_in[CH-1-k];
  end
  // output mux selects only on committed mode bits, so shifting cannot glitch it
  always_comb begin
    beg = '0;
    for (int i = 0; i < CH; i++)
      beg[i] = active[2*i+:2] == 2'b00 ? rev[i] :
               active[2*i+:2] == 2'b01 ? p1[i] :
               active[2*i+:2] == 2'b10 ? p2[i] : 1'b0;
  end
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      p1     <= '0;
      p2     <= '0;
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      p1 <= rev;
      p2 <= p1;
      if (bus.cfg_shift_en) shadow <= {shadow[2*CH-2:0], bus.cfg_din};
      if (legal) begin
        active <= shadow;
        cnt    <= '0;
      end else if (bus.cfg_shift_en && !full) cnt <= cnt + 1'b1;
      if (bus.cfg_commit && !legal) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_term_loopback_cfg.sv
// tb_term_loopback_cfg: directed checks of mapping, modes, config chain and reset
module tb_term_loopback_cfg;
  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   passed = 0;
  localparam logic [71:0] W01 = {36{2'b01}};
  localparam logic [71:0] WMX = 72'h0E;
  localparam logic [71:0] PA  = 72'h9C_3A5F_0E71_B2D4_6C18;
  localparam logic [35:0] ONES = '1;
  term_loopback_cfg_if #(.CH(36)) bus ();
  term_loopback_cfg dut (.UserCLK(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %h exp %h", tag, got, exp);
  endtask
  task automatic shift_range(input logic [71:0] w, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      bus.cfg_din = w[b];
      bus.cfg_shift_en = 1'b1;
      tick();
    end
    bus.cfg_shift_en = 1'b0;
  endtask
  task automatic commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask
  initial begin
    resetn = 1'b0;
    bus.cfg_shift_en = 1'b0;
    bus.cfg_din = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.end_in = 36'h0_0000_0001;
    #1 chk("rst_n1end0", bus.beg_out, 36'h0_0000_0008);
    bus.end_in = 36'h8_0000_0000;
    #1 chk("rst_n4end15", bus.beg_out, 36'h0_0010_0000);
    bus.end_in = 36'h0_0000_0010;
    #1 chk("rst_n2mid0", bus.beg_out, 36'h0_0000_0800);
    bus.end_in = 36'h0_0000_1000;
    #1 chk("rst_n2end0", bus.beg_out, 36'h0_0008_0000);
    chk("rst_full", 36'(bus.cfg_full), 36'h0);
    chk("rst_err", 36'(bus.cfg_err), 36'h0);
    chk("rst_dout", 36'(bus.cfg_dout), 36'h0);
    bus.end_in = '0;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    shift_range(W01, 71, 1);
    chk("full_71", 36'(bus.cfg_full), 36'h0);
    shift_range(W01, 0, 0);
    chk("full_72", 36'(bus.cfg_full), 36'h1);
    chk("noglitch", bus.beg_out, 36'h0);
    commit();
    chk("full_commit", 36'(bus.cfg_full), 36'h0);
    bus.end_in = 36'h0_0010_0000;
    #1 chk("m01_t0", bus.beg_out, 36'h0);
    tick();
    chk("m01_t1", bus.beg_out, 36'h8_0000_0000);
    bus.end_in = '0;
    #1 chk("m01_hold", bus.beg_out, 36'h8_0000_0000);
    tick();
    chk("m01_fall", bus.beg_out, 36'h0);
    shift_range(WMX, 71, 0);
    commit();
    bus.end_in = ONES;
    #1 chk("mix_t0", bus.beg_out, 36'hF_FFFF_FFFC);
    tick();
    chk("mix_t1", bus.beg_out, 36'hF_FFFF_FFFC);
    tick();
    chk("mix_t2", bus.beg_out, 36'hF_FFFF_FFFD);
    shift_range(W01, 71, 1);
    commit();
    chk("ill1_err", 36'(bus.cfg_err), 36'h1);
    chk("ill1_full", 36'(bus.cfg_full), 36'h0);
    chk("ill1_beg", bus.beg_out, 36'hF_FFFF_FFFD);
    bus.cfg_din = W01[0];
    bus.cfg_shift_en = 1'b1;
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_shift_en = 1'b0;
    bus.cfg_commit = 1'b0;
    chk("ill2_err", 36'(bus.cfg_err), 36'h1);
    chk("ill2_full", 36'(bus.cfg_full), 36'h1);
    chk("ill2_beg", bus.beg_out, 36'hF_FFFF_FFFD);
    commit();
    chk("clean_full", 36'(bus.cfg_full), 36'h0);
    chk("clean_beg", bus.beg_out, ONES);
    chk("clean_err", 36'(bus.cfg_err), 36'h1);
    shift_range(PA, 71, 0);
    chk("chain_full", 36'(bus.cfg_full), 36'h1);
    for (int k = 0; k < 72; k++) begin
      chk($sformatf("chain_dout%0d", k), 36'(bus.cfg_dout), 36'(PA[71-k]));
      bus.cfg_din = ~PA[71-k];
      bus.cfg_shift_en = 1'b1;
      tick();
    end
    bus.cfg_shift_en = 1'b0;
    chk("chain_sat", 36'(bus.cfg_full), 36'h1);
    chk("chain_beg", bus.beg_out, ONES);
    shift_range(PA, 71, 32);
    bus.end_in = 36'h0_0000_0001;
    resetn = 1'b0;
    #1 chk("mrst_beg", bus.beg_out, 36'h0_0000_0008);
    chk("mrst_full", 36'(bus.cfg_full), 36'h0);
    chk("mrst_err", 36'(bus.cfg_err), 36'h0);
    chk("mrst_dout", 36'(bus.cfg_dout), 36'h0);
    #3 resetn = 1'b1;
    tick();
    bus.end_in = 36'h8_0000_0000;
    #1 chk("mrst_m00", bus.beg_out, 36'h0_0010_0000);
    chk("mrst_full2", 36'(bus.cfg_full), 36'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
